// File: rtl/ram_master_pkg.sv
// Shared encodings for the peripheral RAM initiator: access sizes, FSM states
// and the load-extension helpers used by the lane aligner.
package ram_master_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic is_unsigned);
        return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic is_unsigned);
        return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Combinational lane logic: byte enables and alignment check from size/address,
// and lane selection plus sign/zero extension of the returned read word.
module ram_lane_align
    import ram_master_pkg::*;
(
    input  logic [1:0]  size_in,
    input  logic [1:0]  addr_lo_in,
    input  logic        unsigned_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  byte_en_out,
    output logic        misaligned_out,
    output logic [31:0] load_data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_in[7:0];
        case (addr_lo_in)
            2'd0:    byte_sel = rdata_in[7:0];
            2'd1:    byte_sel = rdata_in[15:8];
            2'd2:    byte_sel = rdata_in[23:16];
            default: byte_sel = rdata_in[31:24];
        endcase
        half_sel = addr_lo_in[1] ? rdata_in[31:16] : rdata_in[15:0];
    end

    always_comb begin
        byte_en_out    = 4'b0000;
        misaligned_out = 1'b0;
        load_data_out  = 32'h0;
        case (size_in)
            MEM_SIZE_B: begin
                byte_en_out   = 4'b0001 << addr_lo_in;
                load_data_out = extend8(byte_sel, unsigned_in);
            end
            MEM_SIZE_H: begin
                byte_en_out    = addr_lo_in[1] ? 4'b1100 : 4'b0011;
                misaligned_out = addr_lo_in[0];
                load_data_out  = extend16(half_sel, unsigned_in);
            end
            MEM_SIZE_W: begin
                byte_en_out    = 4'b1111;
                misaligned_out = (addr_lo_in != 2'b00);
                load_data_out  = rdata_in;
            end
            default: begin
                // Size 11 is reserved and always rejected.
                misaligned_out = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ram_master.sv
// Initiator for the peripheral RAM valid/ready + rdata_valid handshake. Takes one
// core load/store at a time and returns a single-cycle response with error flag.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_err_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] ram_addr_out,
    output logic [31:0] ram_write_data_out,
    output logic        ram_read_en_out,
    output logic        ram_write_en_out,
    output logic [3:0]  ram_write_byte_en_out,
    input  logic        rdata_valid_in,
    input  logic [31:0] ram_read_data_in
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]  al_size;
    logic [1:0]  al_addr_lo;
    logic        al_unsigned;
    logic [3:0]  al_byte_en;
    logic        al_misaligned;
    logic [31:0] al_load_data;

    // In IDLE the aligner judges the incoming request; afterwards it works on the captured one.
    always_comb begin
        al_size     = size_q;
        al_addr_lo  = addr_q[1:0];
        al_unsigned = unsigned_q;
        if (state_q == ST_IDLE) begin
            al_size     = req_size_in;
            al_addr_lo  = req_addr_in[1:0];
            al_unsigned = req_unsigned_in;
        end
    end

    ram_lane_align u_lane_align (
        .size_in        (al_size),
        .addr_lo_in     (al_addr_lo),
        .unsigned_in    (al_unsigned),
        .rdata_in       (ram_read_data_in),
        .byte_en_out    (al_byte_en),
        .misaligned_out (al_misaligned),
        .load_data_out  (al_load_data)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        req_ready_out         = 1'b0;
        resp_valid_out        = 1'b0;
        resp_rdata_out        = 32'h0;
        resp_err_out          = 1'b0;
        valid_out             = 1'b0;
        ram_addr_out          = 32'h0;
        ram_write_data_out    = 32'h0;
        ram_read_en_out       = 1'b0;
        ram_write_en_out      = 1'b0;
        ram_write_byte_en_out = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    we_d       = req_we_in;
                    size_d     = req_size_in;
                    unsigned_d = req_unsigned_in;
                    addr_d     = req_addr_in;
                    wdata_d    = req_wdata_in;
                    cnt_d      = '0;
                    rdata_d    = 32'h0;
                    err_d      = al_misaligned;
                    state_d    = al_misaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                valid_out    = 1'b1;
                ram_addr_out = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    ram_write_en_out      = 1'b1;
                    ram_write_data_out    = wdata_q;
                    ram_write_byte_en_out = al_byte_en;
                end else begin
                    ram_read_en_out = 1'b1;
                end
                if (ready_in) begin
                    cnt_d   = '0;
                    state_d = we_q ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (rdata_valid_in) begin
                    rdata_d = al_load_data;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                resp_valid_out = 1'b1;
                resp_rdata_out = rdata_q;
                resp_err_out   = err_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            cnt_q      <= '0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: stores/loads of every size against a small RAM
// slave model, misaligned rejects, REQ stall, read timeout and mid-read reset.
module tb_ram_master;
    import ram_master_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_we_in = 1'b0;
    logic [1:0]  req_size_in = 2'b00;
    logic        req_unsigned_in = 1'b0;
    logic [31:0] req_addr_in = 32'h0;
    logic [31:0] req_wdata_in = 32'h0;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_err_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [31:0] ram_addr_out;
    logic [31:0] ram_write_data_out;
    logic        ram_read_en_out;
    logic        ram_write_en_out;
    logic [3:0]  ram_write_byte_en_out;
    logic        rdata_valid_in = 1'b0;
    logic [31:0] ram_read_data_in = 32'h0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    ram_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                   (clk),
        .rst                   (rst_n),
        .req_valid_in          (req_valid_in),
        .req_ready_out         (req_ready_out),
        .req_we_in             (req_we_in),
        .req_size_in           (req_size_in),
        .req_unsigned_in       (req_unsigned_in),
        .req_addr_in           (req_addr_in),
        .req_wdata_in          (req_wdata_in),
        .resp_valid_out        (resp_valid_out),
        .resp_rdata_out        (resp_rdata_out),
        .resp_err_out          (resp_err_out),
        .valid_out             (valid_out),
        .ready_in              (ready_in),
        .ram_addr_out          (ram_addr_out),
        .ram_write_data_out    (ram_write_data_out),
        .ram_read_en_out       (ram_read_en_out),
        .ram_write_en_out      (ram_write_en_out),
        .ram_write_byte_en_out (ram_write_byte_en_out),
        .rdata_valid_in        (rdata_valid_in),
        .ram_read_data_in      (ram_read_data_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, plays the RAM slave (ready at once, read data one cycle
    // after the handshake) and checks bus fields, latency and the response.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat);
        int lat;
        int bus_cycles;
        int lane;
        logic pend;
        logic [31:0] wsh;
        exp_q.push_back(exp_data);
        check({tag, " ready_idle"}, 32'(req_ready_out), 32'd1);
        req_valid_in = 1'b1;
        req_we_in = we;
        req_size_in = size;
        req_unsigned_in = uns;
        req_addr_in = addr;
        req_wdata_in = wdata;
        ready_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
        req_we_in = 1'b0;
        req_addr_in = 32'h0;
        req_wdata_in = 32'h0;
        pend = 1'b0;
        lat = 0;
        bus_cycles = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            rdata_valid_in = pend;
            ram_read_data_in = pend ? mem[addr[5:2]] : 32'h0;
            pend = 1'b0;
            if (resp_valid_out) begin
                lat = cyc;
                break;
            end
            if (valid_out) begin
                bus_cycles++;
                check({tag, " addr"}, ram_addr_out, {addr[31:2], 2'b00});
                check({tag, " be"}, 32'(ram_write_byte_en_out), 32'(exp_be));
                check({tag, " wen"}, 32'(ram_write_en_out), 32'(we));
                check({tag, " ren"}, 32'(ram_read_en_out), 32'(!we));
                if (we) begin
                    check({tag, " wdata"}, ram_write_data_out, wdata);
                    lane = ram_write_byte_en_out[0] ? 0 : ram_write_byte_en_out[1] ? 1 :
                           ram_write_byte_en_out[2] ? 2 : 3;
                    wsh = ram_write_data_out << (8 * lane);
                    for (int i = 0; i < 4; i++)
                        if (ram_write_byte_en_out[i]) mem[addr[5:2]][8*i +: 8] = wsh[8*i +: 8];
                end else begin
                    pend = 1'b1;
                end
            end
            tick();
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " bus_cycles"}, 32'(bus_cycles), exp_err ? 32'd0 : 32'd1);
        check({tag, " rdata"}, resp_rdata_out, exp_q.pop_front());
        check({tag, " err"}, 32'(resp_err_out), 32'(exp_err));
        rdata_valid_in = 1'b0;
        ram_read_data_in = 32'h0;
        ready_in = 1'b0;
        tick();
        check({tag, " pulse_end"}, 32'(resp_valid_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        tick();
        tick();
        check("reset ready", 32'(req_ready_out), 32'd1);
        check("reset valid_out", 32'(valid_out), 32'd0);
        check("reset resp_valid", 32'(resp_valid_out), 32'd0);
        check("reset addr", ram_addr_out, 32'h0);
        rst_n = 1'b1;
        tick();

        access("SW@10",  1'b1, MEM_SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 2);
        access("LW@10",  1'b0, MEM_SIZE_W, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 3);
        access("SB@13",  1'b1, MEM_SIZE_B, 1'b0, 32'h13, 32'h000000A5, 4'b1000, 32'h0, 1'b0, 2);
        access("LB@13",  1'b0, MEM_SIZE_B, 1'b0, 32'h13, 32'h0, 4'b0000, 32'hFFFFFFA5, 1'b0, 3);
        access("LBU@13", 1'b0, MEM_SIZE_B, 1'b1, 32'h13, 32'h0, 4'b0000, 32'h000000A5, 1'b0, 3);
        access("SH@22",  1'b1, MEM_SIZE_H, 1'b0, 32'h22, 32'h00008001, 4'b1100, 32'h0, 1'b0, 2);
        access("LH@22",  1'b0, MEM_SIZE_H, 1'b0, 32'h22, 32'h0, 4'b0000, 32'hFFFF8001, 1'b0, 3);
        access("LHU@22", 1'b0, MEM_SIZE_H, 1'b1, 32'h22, 32'h0, 4'b0000, 32'h00008001, 1'b0, 3);
        access("SB@21",  1'b1, MEM_SIZE_B, 1'b0, 32'h21, 32'h0000007F, 4'b0010, 32'h0, 1'b0, 2);
        access("LB@21",  1'b0, MEM_SIZE_B, 1'b0, 32'h21, 32'h0, 4'b0000, 32'h0000007F, 1'b0, 3);
        access("LH@20",  1'b0, MEM_SIZE_H, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h00007F00, 1'b0, 3);
        access("LW@20",  1'b0, MEM_SIZE_W, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h80017F00, 1'b0, 3);
        access("LW@06",  1'b0, MEM_SIZE_W, 1'b0, 32'h06, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
        access("LH@21",  1'b0, MEM_SIZE_H, 1'b0, 32'h21, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
        access("SZ11@0", 1'b1, 2'b11,      1'b0, 32'h00, 32'h1, 4'b0000, 32'h0, 1'b1, 1);

        // Stray read data while idle must not produce a response.
        rdata_valid_in = 1'b1;
        ram_read_data_in = 32'h11111111;
        tick();
        check("stray rdv resp", 32'(resp_valid_out), 32'd0);
        check("stray rdv ready", 32'(req_ready_out), 32'd1);
        rdata_valid_in = 1'b0;
        ram_read_data_in = 32'h0;

        // Stall in REQ for five cycles, then let the read time out.
        req_valid_in = 1'b1;
        req_we_in = 1'b0;
        req_size_in = MEM_SIZE_W;
        req_unsigned_in = 1'b0;
        req_addr_in = 32'h40;
        ready_in = 1'b0;
        tick();
        req_valid_in = 1'b0;
        req_addr_in = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall valid", 32'(valid_out), 32'd1);
            check("stall addr", ram_addr_out, 32'h40);
            check("stall ren", 32'(ram_read_en_out), 32'd1);
            check("stall be", 32'(ram_write_byte_en_out), 32'd0);
            check("stall ready", 32'(req_ready_out), 32'd0);
            tick();
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (resp_valid_out) begin
                lat = cyc;
                break;
            end
            tick();
        end
        check("timeout latency", 32'(lat), 32'(TIMEOUT + 1));
        check("timeout err", 32'(resp_err_out), 32'd1);
        check("timeout rdata", resp_rdata_out, 32'h0);
        tick();
        check("timeout ready", 32'(req_ready_out), 32'd1);

        // Reset while waiting in RESP; late read data must be dropped.
        req_valid_in = 1'b1;
        req_size_in = MEM_SIZE_W;
        req_addr_in = 32'h10;
        ready_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
        req_addr_in = 32'h0;
        tick();
        ready_in = 1'b0;
        check("resp no valid", 32'(valid_out), 32'd0);
        check("resp ready", 32'(req_ready_out), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst ready", 32'(req_ready_out), 32'd1);
        check("rst valid_out", 32'(valid_out), 32'd0);
        check("rst resp_valid", 32'(resp_valid_out), 32'd0);
        check("rst ren", 32'(ram_read_en_out), 32'd0);
        tick();
        rst_n = 1'b1;
        rdata_valid_in = 1'b1;
        ram_read_data_in = 32'h12345678;
        tick();
        check("late rdv resp", 32'(resp_valid_out), 32'd0);
        rdata_valid_in = 1'b0;
        ram_read_data_in = 32'h0;
        tick();
        check("late rdv resp2", 32'(resp_valid_out), 32'd0);
        check("late rdv ready", 32'(req_ready_out), 32'd1);

        access("LW@10 post", 1'b0, MEM_SIZE_W, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hA5ADBEEF, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
